seven_segment_reader: RTL
=========================

Name: seven_segment_reader

Overview:
- Observes a multiplexed seven-segment display bus (one-hot digit select plus 7-bit segment code) and recovers the 4-bit number shown on each digit.
- This is the inverse of the team's seven-segment driver encoding.
- Filters bus transitions, then streams decoded digits over a valid/ready interface.
- Per full scan frame, reports the smallest digit value and whether all digits are equal. Used for display self-check and loopback tests.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8)
STABLE_CYCLES, 3, consecutive identical samples required before a digit is accepted (1..15)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
digit_sel  in  DIGITS  one-hot active digit; zero means blanked
seg_code  in  7  segment code for the active digit
out_valid  out  1  decoded digit available
out_ready  in  1  consumer accepts the digit
out_index  out  3  digit index (bit position in digit_sel)
out_number  out  4  decoded value
out_error  out  1  seg_code was not a legal code
overflow  out  1  sticky; a digit was dropped because the buffer was full
frame_done  out  1  one-cycle pulse when every digit has been captured since the last frame
frame_min  out  4  smallest non-error value in the completed frame
frame_equal  out  1  all non-error values in the completed frame are identical

Behaviour:
- Reset (async, rst_n=0): filter enters IDLE with run count 0. All outputs drop to 0, including overflow, frame_min and frame_equal. The frame-seen mask clears. Reset mid-operation discards any buffered digit.
- Decode table (code -> number): 77->0, 24->1, 5d->2, 6d->3, 2e->4, 6b->5, 7b->6, 25->7, 7f->8, 6f->9, 3f->A, 7a->B, 53->C, 7c->D, 5b->E, 1b->F.
- Any other code gives out_error=1 with out_number=0.
- Filter FSM, sampled every rising edge:
  - IDLE: digit_sel not one-hot (zero or multi-hot). Run count held at 0. Goes to COUNT on a one-hot sample, storing the pair with run=1.
  - COUNT: same pair -> run+1; different one-hot pair -> restart at run=1; non-one-hot -> IDLE.
  - Entry to LOCKED: on the edge where run reaches STABLE_CYCLES, emit one accept event and go to LOCKED. With STABLE_CYCLES=1, the first one-hot sample emits immediately.
  - LOCKED: same pair -> no further events; different one-hot pair -> COUNT with run=1; non-one-hot -> IDLE.
- Latency: with the pair present on edges 1..STABLE_CYCLES, out_valid is visible after edge STABLE_CYCLES.
- Output buffer: a single entry.
  - out_index, out_number and out_error are stable while out_valid=1.
  - An entry retires on an edge where out_valid and out_ready are both 1.
  - If an accept event coincides with a retire, the new entry loads (out_valid stays 1).
  - If an accept event arrives while the buffer is full and not retiring, the new digit is dropped and overflow is set.
  - The buffered digit is never overwritten.
- Frame tracking is updated on every accept event, whether or not the digit was dropped.
  - Sets the seen-mask bit for the digit's index.
  - Folds the value into the running min and running equal state; error digits are excluded.
  - When the mask becomes all-ones: frame_done pulses on the next cycle, frame_min and frame_equal register the results, and the mask, running min and equal state clear.
  - If every digit in a frame was an error: frame_min=F and frame_equal=0.
  - A digit index repeated within a frame overwrites nothing; it still folds into min/equal.
- Widths: out_index is the one-hot to binary encoding, zero-extended to 3 bits. Compares are unsigned 4-bit.

Decomposition:
- Package seven_segment_pkg holds:
  - the 16-entry code constant table (shared with the driver);
  - the ILLEGAL flag encoding;
  - the filter state enum {IDLE, COUNT, LOCKED}.
- Sub-module seven_segment_decoder: combinational, 7-bit code in, 4-bit number plus error out. Reused by any other consumer of the encoding.
- The filter, buffer and frame logic stay in the top module.

Test Plan:
- Stable digit: digit_sel=0001, seg_code=5d held 3 edges, out_ready=1 -> out_valid after edge 3 with index=0, number=2, error=0. Exactly one event over 10 held edges.
- Glitch reject: seg_code 7f for 2 edges, then 6f for 3 edges on digit_sel=0010 -> a single event index=1, number=9. No event for 8.
- Illegal and blank: seg_code=00 held 3 edges -> error=1, number=0. digit_sel=0000 or 0011 for any duration -> no event, FSM in IDLE.
- Backpressure: out_ready=0; accept a digit on index 0, then on index 1 -> index 0 retained, overflow=1. Raise out_ready -> index 0 retires, out_valid drops.
- Frame: digits 0..3 show 7,3,3,C -> frame_done pulses once, frame_min=3, frame_equal=0. Next frame all 5 -> frame_min=5, frame_equal=1.
- Reset mid-run: assert rst_n=0 with out_valid=1 and run=2 -> all outputs 0 immediately, asynchronously. After release, a new digit needs a full STABLE_CYCLES run.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared seven-segment encoding table and reader types
package seven_segment_pkg;

    // Index is the digit value; the same table drives the display encoder.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h77, 7'h24, 7'h5d, 7'h6d, 7'h2e, 7'h6b, 7'h7b, 7'h25,
        7'h7f, 7'h6f, 7'h3f, 7'h7a, 7'h53, 7'h7c, 7'h5b, 7'h1b
    };

    typedef struct packed {
        logic       error;
        logic [3:0] number;
    } seg_decode_t;

    localparam seg_decode_t ILLEGAL = '{error: 1'b1, number: 4'h0};

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        LOCKED
    } filt_state_e;

endpackage

// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - combinational segment code to digit value decoder
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [6:0] code_i,
    output logic [3:0] number_o,
    output logic       error_o
);

    seg_decode_t dec;

    always_comb begin
        dec = ILLEGAL;
        for (int i = 0; i < 16; i++) begin
            if (code_i == SEG_TABLE[i]) begin
                dec = '{error: 1'b0, number: 4'(i)};
            end
        end
    end

    assign number_o = dec.number;
    assign error_o  = dec.error;

endmodule

// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - filters a multiplexed 7-seg bus, streams decoded digits, tracks frames
module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIGITS-1:0] digit_sel,
    input  logic [6:0]        seg_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_index,
    output logic [3:0]        out_number,
    output logic              out_error,
    output logic              overflow,
    output logic              frame_done,
    output logic [3:0]        frame_min,
    output logic              frame_equal
);

    localparam logic [3:0] STABLE_RUN = 4'(STABLE_CYCLES);

    filt_state_e       state_q, state_d;
    logic [3:0]        run_q, run_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [6:0]        code_q, code_d;
    logic              accept;
    logic              onehot;

    logic              valid_q, err_q, ovf_q, done_q, fequal_q;
    logic [2:0]        idx_q;
    logic [3:0]        num_q, fmin_q;

    logic [DIGITS-1:0] mask_q, mask_d;
    logic              have_q, have_d;
    logic [3:0]        min_q, min_d;
    logic              eq_q, eq_d;

    logic [3:0]        dec_number;
    logic              dec_error;
    logic [2:0]        idx;
    logic              retire;
    logic              frame_complete;

    seven_segment_decoder u_decoder (
        .code_i   (seg_code),
        .number_o (dec_number),
        .error_o  (dec_error)
    );

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_sel[i]) idx = i[2:0];
        end
    end

    always_comb begin
        onehot  = (digit_sel != '0) && ((digit_sel & (digit_sel - 1'b1)) == '0);
        state_d = state_q;
        run_d   = run_q;
        sel_d   = sel_q;
        code_d  = code_q;
        accept  = 1'b0;
        if (!onehot) begin
            state_d = IDLE;
            run_d   = 4'd0;
        end else if (state_q != IDLE && digit_sel == sel_q && seg_code == code_q) begin
            if (state_q == COUNT) begin
                run_d = run_q + 4'd1;
                if (run_d == STABLE_RUN) begin
                    accept  = 1'b1;
                    state_d = LOCKED;
                end
            end
        end else begin
            // New pair (or first sample after blanking) restarts the stability run.
            sel_d  = digit_sel;
            code_d = seg_code;
            run_d  = 4'd1;
            if (STABLE_RUN == 4'd1) begin
                accept  = 1'b1;
                state_d = LOCKED;
            end else begin
                state_d = COUNT;
            end
        end
    end

    always_comb begin
        mask_d = mask_q | (DIGITS'(1) << idx);
        have_d = have_q;
        min_d  = min_q;
        eq_d   = eq_q;
        if (!dec_error) begin
            if (!have_q) begin
                have_d = 1'b1;
                min_d  = dec_number;
                eq_d   = 1'b1;
            end else begin
                min_d = (dec_number < min_q) ? dec_number : min_q;
                eq_d  = eq_q && (dec_number == min_q);
            end
        end
        frame_complete = accept && (mask_d == '1);
    end

    assign retire = valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            run_q    <= 4'd0;
            sel_q    <= '0;
            code_q   <= 7'd0;
            valid_q  <= 1'b0;
            idx_q    <= 3'd0;
            num_q    <= 4'd0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            fmin_q   <= 4'd0;
            fequal_q <= 1'b0;
            mask_q   <= '0;
            have_q   <= 1'b0;
            min_q    <= 4'd0;
            eq_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            sel_q   <= sel_d;
            code_q  <= code_d;
            done_q  <= 1'b0;

            if (accept && (!valid_q || retire)) begin
                valid_q <= 1'b1;
                idx_q   <= idx;
                num_q   <= dec_number;
                err_q   <= dec_error;
            end else if (accept) begin
                ovf_q <= 1'b1;
            end else if (retire) begin
                valid_q <= 1'b0;
            end

            if (frame_complete) begin
                done_q   <= 1'b1;
                fmin_q   <= have_d ? min_d : 4'hF;
                fequal_q <= have_d && eq_d;
                mask_q   <= '0;
                have_q   <= 1'b0;
                min_q    <= 4'd0;
                eq_q     <= 1'b0;
            end else if (accept) begin
                mask_q <= mask_d;
                have_q <= have_d;
                min_q  <= min_d;
                eq_q   <= eq_d;
            end
        end
    end

    assign out_valid   = valid_q;
    assign out_index   = idx_q;
    assign out_number  = num_q;
    assign out_error   = err_q;
    assign overflow    = ovf_q;
    assign frame_done  = done_q;
    assign frame_min   = fmin_q;
    assign frame_equal = fequal_q;

endmodule
